adder_tree_arbiter: RTL and testbench

- Shares one serial adder_tree instance between NUM_REQ requesters, such as per-channel convolution lanes.
- Arbitrates requests round-robin and latches the winner's packed operand bus.
- Sequences the adder (single-cycle enable pulse, then wait for done), captures the sum and returns it to the owning requester over a valid/ready response.
- Includes a watchdog so a stuck adder cannot hang the array.

---
 rtl/adder_tree_arbiter.sv | 164 ++++++++++++++++
 tb/tb_adder_tree_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_arbiter.sv
// adder_tree_arbiter: shares one serial adder between NUM_REQ requesters.
// A round-robin arbiter picks a requester in IDLE and latches its operands.
// The adder gets a one-cycle start pulse, and the arbiter then waits for done
// or for the watchdog. The sum goes back to the owning requester.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. On the request side, req_ready is a combinational one-hot grant
// that is only raised in IDLE. On the response side, rsp_valid is one-hot on
// the owner's line, and rsp_data/rsp_err stay stable until that owner's
// rsp_ready is high.
module adder_tree_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 1,
  parameter int TIMEOUT      = 64,
  localparam int IN_W  = (DATA_WIDTH + WEIGHT_WIDTH) * KERNEL_SIZE,
  localparam int OUT_W = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    adder_en,
  output logic [IN_W-1:0]         adder_dataIn,
  input  logic [OUT_W-1:0]        adder_dataOut,
  input  logic                    adder_done,
  output logic                    busy,
  output logic                    err_sticky,
  output logic [1:0]              dbg_state_o,
  output logic [ID_W-1:0]         dbg_rr_ptr_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  // Encoding is fixed so that the dbg_state_o values stay stable:
  // IDLE=0, LAUNCH=1, WAIT=2, RESP=3.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [IN_W-1:0]   data_in_q, data_in_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   arb_idx;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  // FSM next-state and handshake outputs; every target gets a default first.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    data_in_d    = data_in_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;
    wdog_d       = wdog_q;
    req_ready    = '0;
    rsp_valid    = '0;
    adder_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          data_in_d  = req_data[int'(grant_idx)*IN_W +: IN_W];
          grant_id_d = grant_idx;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        adder_en = 1'b1;
        wdog_d   = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse takes priority over a watchdog expiry in the same cycle.
        if (adder_done) begin
          rsp_data_d = adder_dataOut;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
          err_sticky_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; rst overrides any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      data_in_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      data_in_q    <= data_in_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
      wdog_q       <= wdog_d;
    end
  end

  assign adder_dataIn = data_in_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign err_sticky   = err_sticky_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Testbench for adder_tree_arbiter. It models the serial adder and keeps a
// round-robin / sum reference model plus an expected-response queue.
module tb_adder_tree_arbiter;

  localparam int NUM_REQ = 4;
  localparam int KS      = 3;
  localparam int DW      = 8;
  localparam int WW      = 1;
  localparam int TO      = 64;
  localparam int OPW     = DW + WW;
  localparam int IN_W    = OPW * KS;
  localparam int OUT_W   = DW + WW + KS;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready = '1;
  logic [OUT_W-1:0]        rsp_data;
  logic                    rsp_err;
  logic                    adder_en;
  logic [IN_W-1:0]         adder_dataIn;
  logic [OUT_W-1:0]        adder_dataOut;
  logic                    adder_done;
  logic                    busy;
  logic                    err_sticky;
  logic [1:0]              dbg_state;
  logic [ID_W-1:0]         dbg_rr_ptr;

  adder_tree_arbiter #(
    .NUM_REQ(NUM_REQ), .KERNEL_SIZE(KS), .DATA_WIDTH(DW),
    .WEIGHT_WIDTH(WW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .adder_en(adder_en), .adder_dataIn(adder_dataIn),
    .adder_dataOut(adder_dataOut), .adder_done(adder_done), .busy(busy),
    .err_sticky(err_sticky), .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // ---------------- reference model ----------------
  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [OUT_W-1:0] model_sum(input logic [IN_W-1:0] v);
    int s = 0;
    for (int k = 0; k < KS; k++) s += int'(v[k*OPW +: OPW]);
    return OUT_W'(s);
  endfunction

  function automatic int model_grant(input logic [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- serial adder model ----------------
  // Busy for KS cycles after the start pulse; done pulses in the cycle after that.
  int               add_cnt = 0;
  logic [OUT_W-1:0] add_sum = '0;
  bit               stuck = 0;
  bit               stray = 0;
  always @(posedge clk) begin
    if (rst) add_cnt <= 0;
    else if (adder_en) begin
      add_cnt <= KS + 1;
      add_sum <= model_sum(adder_dataIn);
    end else if (add_cnt > 0) add_cnt <= add_cnt - 1;
  end
  assign adder_done    = ((add_cnt == 1) && !stuck) || stray;
  assign adder_dataOut = add_sum;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '1; stuck = 0; stray = 0;
    tick(); tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Issues one request on line id, waits for the response (rsp_ready must be high),
  // and returns what it saw. On return the response handshake edge has passed.
  task automatic do_op(input int id, input logic [IN_W-1:0] data, output bit ok,
                       output int t_acc, output int t_rsp, output logic [OUT_W-1:0] d,
                       output logic e, output logic [NUM_REQ-1:0] rv);
    int n;
    ok = 0; t_acc = -1; t_rsp = -1; d = '0; e = 1'b0; rv = '0;
    req_data[id*IN_W +: IN_W] = data;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 200) begin tick(); #1; n++; end
    if (req_ready[id] !== 1'b1) begin req_valid[id] = 1'b0; return; end
    t_acc = cyc;
    tick();
    req_valid[id] = 1'b0;
    #1;
    n = 0;
    while (rsp_valid === '0 && n < 200) begin tick(); #1; n++; end
    if (rsp_valid === '0) return;
    t_rsp = cyc; d = rsp_data; e = rsp_err; rv = rsp_valid; ok = 1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (adder_en !== 1'b0) begin errors++; $display("FAIL reset_adder_en got=%b exp=0", adder_en); end
    checks++; if (adder_dataIn !== '0) begin errors++; $display("FAIL reset_dataIn got=%h exp=0", adder_dataIn); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== ST_IDLE || dbg_rr_ptr !== '0)
      begin errors++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_rr_ptr); end
  endtask

  task automatic test_single_op();
    int t, n;
    logic [IN_W-1:0] data;
    data = {9'd5, 9'd7, 9'd3};
    req_data[2*IN_W +: IN_W] = data;
    rsp_ready = '1;
    req_valid = 4'b0100;
    #1;
    t = cyc;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_accept got=%b exp=0100", req_ready); end
    tick(); req_valid = '0; #1;
    checks++; if (adder_en !== 1'b1) begin errors++; $display("FAIL single_en_T1 got=%b exp=1", adder_en); end
    tick(); #1;
    checks++; if (adder_en !== 1'b0) begin errors++; $display("FAIL single_en_T2 got=%b exp=0", adder_en); end
    n = 0;
    while (rsp_valid === '0 && n < 50) begin tick(); #1; n++; end
    checks++; if (cyc - t != KS + 3) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", cyc - t, KS + 3); end
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_data !== OUT_W'(15) || rsp_err !== 1'b0)
      begin errors++; $display("FAIL single_rsp_data got=%0d/%b exp=15/0", rsp_data, rsp_err); end
    checks++; if (adder_dataIn !== data) begin errors++; $display("FAIL single_dataIn_held got=%h exp=%h", adder_dataIn, data); end
    tick(); #1;
    checks++; if (dbg_rr_ptr !== ID_W'(3) || busy !== 1'b0)
      begin errors++; $display("FAIL single_rr_ptr got=%0d busy=%b exp=3 busy=0", dbg_rr_ptr, busy); end
    model_ptr = 3;
  endtask

  task automatic test_round_robin();
    int grants, n, g, last_g, last_t, eg;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*IN_W +: IN_W] = IN_W'($urandom);
    rsp_ready = '1;
    req_valid = '1;
    #1;
    grants = 0; n = 0; last_g = -1; last_t = 0;
    while (grants < 5 && n < 100) begin
      if (req_ready !== '0) begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
        eg = model_grant(req_valid);
        checks++; if (g != eg || $countones(req_ready) != 1)
          begin errors++; $display("FAIL rr_grant got=%b exp_id=%0d", req_ready, eg); end
        if (grants > 0) begin
          checks++; if (cyc - last_t != KS + 4 || g == last_g)
            begin errors++; $display("FAIL rr_spacing got=%0d id=%0d last=%0d exp=%0d", cyc - last_t, g, last_g, KS + 4); end
        end
        exp_q.push_back(model_sum(req_data[eg*IN_W +: IN_W]));
        model_ptr = (eg + 1) % NUM_REQ;
        last_g = g; last_t = cyc; grants++;
      end
      if (rsp_valid !== '0 && exp_q.size() > 0) begin
        checks++; if (rsp_data !== exp_q[0]) begin errors++; $display("FAIL rr_rsp_data got=%0d exp=%0d", rsp_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick(); #1; n++;
    end
    checks++; if (grants != 5) begin errors++; $display("FAIL rr_grant_count got=%0d exp=5", grants); end
    req_valid = '0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      if (rsp_valid !== '0) begin
        checks++; if (rsp_data !== exp_q[0]) begin errors++; $display("FAIL rr_last_rsp got=%0d exp=%0d", rsp_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick(); #1; n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic [OUT_W-1:0] snap, exp_sum;
    logic [IN_W-1:0] d0;
    bit ok; int ta, tr; logic [OUT_W-1:0] d; logic e; logic [NUM_REQ-1:0] rv;
    req_data[1*IN_W +: IN_W] = IN_W'($urandom);
    exp_sum = model_sum(req_data[1*IN_W +: IN_W]);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
    model_ptr = 2;
    tick(); req_valid = '0; #1;
    n = 0;
    while (rsp_valid === '0 && n < 50) begin tick(); #1; n++; end
    snap = rsp_data;
    checks++; if (snap !== exp_sum) begin errors++; $display("FAIL bp_sum got=%0d exp=%0d", snap, exp_sum); end
    d0 = IN_W'($urandom);
    req_data[0 +: IN_W] = d0;
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_data !== snap || busy !== 1'b1 || req_ready !== '0)
        begin errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d busy=%b rdy=%b exp=0010/%0d/1/0000", i, rsp_valid, rsp_data, busy, req_ready, snap); end
    end
    rsp_ready = '1;
    tick(); #1;
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || req_ready !== 4'b0001)
      begin errors++; $display("FAIL bp_release state=%0d busy=%b rdy=%b exp=0/0/0001", dbg_state, busy, req_ready); end
    req_valid = '0;
    do_op(0, d0, ok, ta, tr, d, e, rv);
    checks++; if (!ok || d !== model_sum(d0) || rv !== 4'b0001)
      begin errors++; $display("FAIL bp_next_op ok=%0d got=%0d exp=%0d", ok, d, model_sum(d0)); end
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    bit ok; int ta, tr; logic [OUT_W-1:0] d; logic e; logic [NUM_REQ-1:0] rv;
    logic [IN_W-1:0] v;
    stuck = 1;
    do_op(2, IN_W'($urandom), ok, ta, tr, d, e, rv);
    checks++; if (!ok || tr - ta != TO + 2)
      begin errors++; $display("FAIL to_latency ok=%0d got=%0d exp=%0d", ok, tr - ta, TO + 2); end
    checks++; if (d !== '0 || e !== 1'b1 || rv !== 4'b0100)
      begin errors++; $display("FAIL to_rsp got=%0d/%b/%b exp=0/1/0100", d, e, rv); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", err_sticky); end
    model_ptr = 3;
    stuck = 0;
    v = IN_W'($urandom);
    do_op(0, v, ok, ta, tr, d, e, rv);
    checks++; if (!ok || d !== model_sum(v) || e !== 1'b0)
      begin errors++; $display("FAIL to_good_after got=%0d/%b exp=%0d/0", d, e, model_sum(v)); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL to_sticky_persist got=%b exp=1", err_sticky); end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid_op();
    bit ok; int ta, tr; logic [OUT_W-1:0] d; logic e; logic [NUM_REQ-1:0] rv;
    logic [IN_W-1:0] v;
    req_data[3*IN_W +: IN_W] = IN_W'($urandom);
    req_valid = 4'b1000;
    tick(); req_valid = '0;
    tick(); tick(); #1;
    checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rmo_in_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    checks++; if (rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || adder_en !== 1'b0 || req_ready !== '0)
      begin errors++; $display("FAIL rmo_outputs valid=%b data=%0d err=%b en=%b rdy=%b exp=all 0", rsp_valid, rsp_data, rsp_err, adder_en, req_ready); end
    checks++; if (adder_dataIn !== '0 || err_sticky !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rmo_regs dataIn=%h sticky=%b busy=%b exp=0/0/0", adder_dataIn, err_sticky, busy); end
    checks++; if (dbg_state !== ST_IDLE || dbg_rr_ptr !== '0)
      begin errors++; $display("FAIL rmo_state got=%0d/%0d exp=0/0", dbg_state, dbg_rr_ptr); end
    model_ptr = 0;
    v = IN_W'($urandom);
    do_op(2, v, ok, ta, tr, d, e, rv);
    checks++; if (!ok || d !== model_sum(v) || e !== 1'b0 || tr - ta != KS + 3)
      begin errors++; $display("FAIL rmo_after got=%0d lat=%0d exp=%0d lat=%0d", d, tr - ta, model_sum(v), KS + 3); end
    model_ptr = 3;
  endtask

  task automatic test_boundaries();
    bit ok; int ta, tr; logic [OUT_W-1:0] d; logic e; logic [NUM_REQ-1:0] rv;
    logic [IN_W-1:0] v;
    v = {KS{9'h1FF}};
    do_op(3, v, ok, ta, tr, d, e, rv);
    checks++; if (!ok || d !== OUT_W'(1533) || e !== 1'b0)
      begin errors++; $display("FAIL bnd_max got=%0d/%b exp=1533/0", d, e); end
    #1;
    checks++; if (dbg_rr_ptr !== '0) begin errors++; $display("FAIL bnd_wrap got=%0d exp=0", dbg_rr_ptr); end
    model_ptr = 0;
    stray = 1;
    tick(); stray = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid !== '0 || busy !== 1'b0 || dbg_state !== ST_IDLE)
        begin errors++; $display("FAIL bnd_stray_done valid=%b busy=%b state=%0d exp=0/0/0", rsp_valid, busy, dbg_state); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] mask, exp_oh;
    int eg, delay, n;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NUM_REQ; i++) req_data[i*IN_W +: IN_W] = IN_W'($urandom);
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      eg = model_grant(mask);
      exp_oh = NUM_REQ'(1) << eg;
      rsp_ready = '0;
      req_valid = mask;
      #1;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rnd_grant it=%0d got=%b exp=%b", it, req_ready, exp_oh); end
      exp_q.push_back(model_sum(req_data[eg*IN_W +: IN_W]));
      tick(); req_valid = '0; #1;
      n = 0;
      while (rsp_valid === '0 && n < 50) begin tick(); #1; n++; end
      delay = $urandom_range(0, 3);
      repeat (delay) begin tick(); #1; end
      checks++; if (rsp_valid !== exp_oh || rsp_data !== exp_q[0] || rsp_err !== 1'b0)
        begin errors++; $display("FAIL rnd_rsp it=%0d got=%b/%0d/%b exp=%b/%0d/0", it, rsp_valid, rsp_data, rsp_err, exp_oh, exp_q[0]); end
      void'(exp_q.pop_front());
      rsp_ready = '1;
      tick();
      model_ptr = (eg + 1) % NUM_REQ;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t limit=500000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
